ws2812_multi: RTL
=================

WS2812_MULTI -- requirements
Module: ws2812_multi

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of independent LED strings (1..8).
REQ-002 SHALL have parameter LEDS_PER_CHANNEL, default 8: LEDs per string (1..256).
REQ-003 SHALL have parameter T_BIT, default 15: clk cycles per bit (1.25 us at 12 MHz).
REQ-004 SHALL have parameter T0H, default 4: high cycles for a 0 bit.
REQ-005 SHALL have parameter T1H, default 9: high cycles for a 1 bit.
REQ-006 SHALL have parameter T_LATCH, default 3600: low cycles after each frame (300 us).
REQ-007 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-008 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port write, input, 1: one-cycle strobe storing rgb_data.
REQ-010 SHALL have port channel, input, 3: target string index.
REQ-011 SHALL have port led_num, input, 8: target LED index within the string.
REQ-012 SHALL have port rgb_data, input, 24: colour word, transmitted MSB first, caller supplies GRB order.
REQ-013 SHALL have port update, input, 1: one-cycle strobe requesting a frame.
REQ-014 SHALL have port auto_refresh, input, 1: when high, frames repeat continuously.
REQ-015 SHALL have port busy, output, 1: frame in progress, including latch.
REQ-016 SHALL have port dropped, output, 1: sticky flag, write rejected while busy.
REQ-017 SHALL have port data, output, NUM_CHANNELS: serial line per string.

Function
REQ-018 SHALL hold a frame buffer of NUM_CHANNELS x LEDS_PER_CHANNEL 24-bit words.
REQ-019 SHALL store a write with busy low into buffer[channel][led_num] at the same edge; write with channel >= NUM_CHANNELS or led_num >= LEDS_PER_CHANNEL SHALL be ignored without setting dropped.
REQ-020 SHALL discard a write with busy high and set dropped; dropped SHALL clear at the edge a new frame starts.
REQ-021 SHALL implement the FSM IDLE -> SEND_HIGH -> SEND_LOW -> (next bit: SEND_HIGH | frame end: LATCH) -> IDLE, or -> SEND_HIGH when a restart is due.
REQ-022 SHALL leave IDLE on update=1 or auto_refresh=1; busy and the first data high SHALL appear in the cycle after that edge.
REQ-023 SHALL drive all channels in lockstep from one shared bit/LED counter; each bit SHALL take exactly T_BIT cycles, data high for T0H or T1H cycles, then low.
REQ-024 SHALL send LED 0 first, bit 23 first, per channel; a frame SHALL last LEDS_PER_CHANNEL*24*T_BIT + T_LATCH cycles with busy high throughout.
REQ-025 SHALL hold data low in IDLE and LATCH.
REQ-026 SHALL latch an update arriving while busy as pending and start exactly one further frame directly after LATCH; multiple pending updates SHALL merge into one.
REQ-027 SHALL, when auto_refresh is high at LATCH end, restart without IDLE; when it is low and no update is pending, return to IDLE, busy low.
REQ-028 SHALL treat write and update in the same IDLE cycle as write stored first, with the frame including the new word.
REQ-029 SHALL size counters with $clog2 of the respective parameter and never wrap within a frame.

Reset
REQ-030 SHALL on reset, asynchronously: data all 0, busy 0, dropped 0, pending 0, FSM IDLE, counters 0, buffer all 0.
REQ-031 SHALL abort a frame in progress on reset, with no partial bit completed after release.

Structure
REQ-032 SHALL take the FSM state enum and default timing constants from the shared package ws2812_pkg.
REQ-033 SHALL instantiate one sub-module ws2812_bit_timer generating high/low phase and bit-done strobe from T_BIT/T0H/T1H; buffer and sequencing stay in ws2812_multi.

Verification (NUM_CHANNELS=2, LEDS_PER_CHANNEL=3, defaults)
REQ-034 SHALL check: write ch0 led0 0xFF0000, ch1 led2 0x000001, then update -> ch0 first 8 bits 9 cycles high and the remaining 64 bits 4 high; ch1 bit 71 only 9 high; busy high 1080+3600 cycles.
REQ-035 SHALL check: write while busy -> dropped=1, buffer unchanged on the next frame, dropped=0 at the next frame start.
REQ-036 SHALL check: 3 updates during one frame -> exactly 2 frames total, no IDLE gap between them.
REQ-037 SHALL check: auto_refresh=1 -> back-to-back frames every 4680 cycles; deassert mid-frame -> IDLE after the current LATCH.
REQ-038 SHALL check: reset asserted at bit 30 -> data=0 and busy=0 immediately; the buffer reads all-zero on the next frame.
REQ-039 SHALL check: write led_num=3 or channel=2 -> ignored, dropped stays 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state encoding, default WS2812 timing and
// a width helper used by the multi-string driver and its bit timer.
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND_HIGH,
    S_SEND_LOW,
    S_LATCH
  } ws_state_e;

  // 12 MHz clock: 1.25 us bit, 0.33/0.75 us highs, 300 us latch
  localparam int DEF_T_BIT   = 15;
  localparam int DEF_T0H     = 4;
  localparam int DEF_T1H     = 9;
  localparam int DEF_T_LATCH = 3600;

  localparam int BITS_PER_LED = 24;

  // Counter width for a range of n values, never below one bit
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: cycle counter for one WS2812 bit slot.
// Ports: clk, reset (async, high), run (slot active),
//   t0_high/t1_high (inside the 0/1 high window), high_end (last
//   cycle of the 1-high window), bit_done (last cycle of the slot).
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic t0_high,
  output logic t1_high,
  output logic high_end,
  output logic bit_done
);

  localparam int CW = cw(T_BIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign t0_high  = run && (cnt < CW'(T0H));
  assign t1_high  = run && (cnt < CW'(T1H));
  assign high_end = run && (cnt == CW'(T1H - 1));
  assign bit_done = run && (cnt == CW'(T_BIT - 1));

endmodule

// File: rtl/ws2812_multi.sv
// ws2812_multi: frame buffer and sequencer driving several WS2812
// strings in lockstep from one shared bit/LED counter.
// Ports: clk, reset (async, high); write/channel/led_num/rgb_data
//   store a GRB word; update/auto_refresh request frames;
//   busy (frame incl. latch), dropped (sticky rejected write),
//   data (one serial line per string).
module ws2812_multi
  import ws2812_pkg::*;
#(
  parameter int NUM_CHANNELS     = 2,
  parameter int LEDS_PER_CHANNEL = 8,
  parameter int T_BIT            = DEF_T_BIT,
  parameter int T0H              = DEF_T0H,
  parameter int T1H              = DEF_T1H,
  parameter int T_LATCH          = DEF_T_LATCH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic [2:0]              channel,
  input  logic [7:0]              led_num,
  input  logic [23:0]             rgb_data,
  input  logic                    update,
  input  logic                    auto_refresh,
  output logic                    busy,
  output logic                    dropped,
  output logic [NUM_CHANNELS-1:0] data
);

  localparam int CHW = cw(NUM_CHANNELS);
  localparam int LW  = cw(LEDS_PER_CHANNEL);
  localparam int BW  = cw(BITS_PER_LED);
  localparam int LCW = cw(T_LATCH);

  ws_state_e state, state_n;

  logic [BW-1:0]  bit_idx;
  logic [LW-1:0]  led_idx;
  logic [LW-1:0]  led_nx;
  logic [LCW-1:0] lat_cnt;
  logic           pending;

  logic [23:0] fb [NUM_CHANNELS][LEDS_PER_CHANNEL];
  logic [23:0] sh [NUM_CHANNELS];

  logic run;
  logic t0_hi;
  logic t1_hi;
  logic high_end;
  logic bit_done;
  logic last_bit;
  logic last_led;
  logic lat_end;
  logic restart;
  logic start;
  logic shift;
  logic wr_ok;

  logic [CHW-1:0] ch_i;
  logic [LW-1:0]  led_i;

  assign ch_i  = channel[CHW-1:0];
  assign led_i = led_num[LW-1:0];

  assign busy = (state != S_IDLE);
  assign run  = (state == S_SEND_HIGH) || (state == S_SEND_LOW);

  assign wr_ok = write && !busy
              && (int'(channel) < NUM_CHANNELS)
              && (int'(led_num) < LEDS_PER_CHANNEL);

  assign last_bit = (bit_idx == BW'(BITS_PER_LED - 1));
  assign last_led = (led_idx == LW'(LEDS_PER_CHANNEL - 1));
  assign led_nx   = led_idx + LW'(1);
  assign lat_end  = (state == S_LATCH)
                 && (lat_cnt == LCW'(T_LATCH - 1));

  // updates seen during the frame, or on its final cycle, merge
  assign restart = pending || update || auto_refresh;
  assign start   = ((state == S_IDLE) && (update || auto_refresh))
                || (lat_end && restart);
  assign shift   = (state == S_SEND_LOW) && bit_done;

  ws2812_bit_timer #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .t0_high  (t0_hi),
    .t1_high  (t1_hi),
    .high_end (high_end),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (update || auto_refresh) state_n = S_SEND_HIGH;
      end
      S_SEND_HIGH: begin
        if (high_end) state_n = S_SEND_LOW;
      end
      S_SEND_LOW: begin
        if (bit_done) begin
          if (last_bit && last_led) state_n = S_LATCH;
          else                      state_n = S_SEND_HIGH;
        end
      end
      S_LATCH: begin
        if (lat_end) state_n = restart ? S_SEND_HIGH : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx <= '0;
      led_idx <= '0;
    end else if (start) begin
      bit_idx <= '0;
      led_idx <= '0;
    end else if (shift) begin
      if (last_bit) begin
        bit_idx <= '0;
        if (!last_led) led_idx <= led_nx;
      end else begin
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if ((state == S_LATCH) && !lat_end) begin
      lat_cnt <= lat_cnt + LCW'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (start) begin
      pending <= 1'b0;
    end else if (update && busy) begin
      pending <= 1'b1;
    end
  end

  // a write rejected on a restart edge still counts as dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped <= 1'b0;
    end else if (write && busy) begin
      dropped <= 1'b1;
    end else if (start) begin
      dropped <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int l = 0; l < LEDS_PER_CHANNEL; l++) begin
          fb[c][l] <= '0;
        end
      end
    end else if (wr_ok) begin
      fb[ch_i][led_i] <= rgb_data;
    end
  end

  // LED 0 is forwarded from a same-edge write so it joins the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        sh[c] <= '0;
      end
    end else if (start) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_ok && (ch_i == CHW'(c)) && (led_num == 8'd0)) begin
          sh[c] <= rgb_data;
        end else begin
          sh[c] <= fb[c][0];
        end
      end
    end else if (shift) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (last_bit && !last_led) begin
          sh[c] <= fb[c][led_nx];
        end else begin
          sh[c] <= {sh[c][22:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      data[c] = t0_hi || (sh[c][23] && t1_hi);
    end
  end

endmodule
